// File: rtl/accel_poll_seq.sv
// Accelerometer poll sequencer: configures the sensor over the byte SPI
// master, then reads X/Y/Z bursts and publishes signed 16-bit samples.
//
// Ports:
//   clk, reset (sync, active low), run     : clock, reset, polling enable
//   spi_done, spi_rdata                    : completion/read data from spi
//   spi_addr, spi_wdata, spi_read          : transaction fields to spi
//   spi_enable                             : one-cycle spi start pulse
//   accel_x/y/z, sample_valid              : published sample + strobe
//   init_done, busy                        : status
module accel_poll_seq #(
   parameter logic [7:0]  CTRL1_ADDR = 8'h20,
   parameter logic [7:0]  CTRL1_VAL  = 8'h57,
   parameter logic [7:0]  CTRL4_ADDR = 8'h23,
   parameter logic [7:0]  CTRL4_VAL  = 8'h08,
   parameter logic [7:0]  OUT_BASE   = 8'h28,
   parameter logic [15:0] GAP_CYCLES = 16'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        spi_done,
   input  logic [7:0]  spi_rdata,
   output logic [7:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   output logic        spi_read,
   output logic        spi_enable,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        sample_valid,
   output logic        init_done,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      CFG_ISSUE,
      CFG_WAIT,
      RD_ISSUE,
      RD_WAIT,
      PUBLISH,
      GAP
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [47:0] shadow_q, shadow_d;
   logic [15:0] gap_q, gap_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        read_q, read_d;
   logic        en_q, en_d;
   logic [15:0] ax_q, ax_d;
   logic [15:0] ay_q, ay_d;
   logic [15:0] az_q, az_d;
   logic        sv_q, sv_d;
   logic        init_q, init_d;
   logic        busy_q, busy_d;
   logic [7:0]  addr_sel;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      gap_d    = gap_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      read_d   = read_q;
      en_d     = 1'b0;
      ax_d     = ax_q;
      ay_d     = ay_q;
      az_d     = az_q;
      sv_d     = 1'b0;
      init_d   = init_q;
      addr_sel = 8'h00;

      unique case (state_q)
         IDLE: begin
            if (run) begin
               idx_d   = 3'd0;
               state_d = init_q ? RD_ISSUE : CFG_ISSUE;
            end
         end
         CFG_ISSUE: state_d = CFG_WAIT;
         CFG_WAIT: begin
            if (spi_done) begin
               if (idx_q == 3'd0) begin
                  idx_d   = 3'd1;
                  state_d = CFG_ISSUE;
               end else begin
                  idx_d   = 3'd0;
                  init_d  = 1'b1;
                  state_d = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (spi_done) begin
               for (int b = 0; b < 6; b++) begin
                  if (idx_q == 3'(b)) shadow_d[b*8 +: 8] = spi_rdata;
               end
               if (idx_q < 3'd5) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = RD_ISSUE;
               end else begin
                  state_d = PUBLISH;
               end
            end
         end
         PUBLISH: begin
            // Even slots are low bytes, odd slots high bytes.
            ax_d    = shadow_q[15:0];
            ay_d    = shadow_q[31:16];
            az_d    = shadow_q[47:32];
            sv_d    = 1'b1;
            gap_d   = GAP_CYCLES;
            state_d = run ? GAP : IDLE;
         end
         GAP: begin
            if (gap_q == 16'd0) begin
               idx_d   = 3'd0;
               state_d = run ? RD_ISSUE : IDLE;
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Transaction fields are launched on entry to an ISSUE state and
      // then held through the matching WAIT state.
      if (state_d == CFG_ISSUE) begin
         en_d     = 1'b1;
         read_d   = 1'b0;
         addr_sel = (idx_d == 3'd0) ? CTRL1_ADDR : CTRL4_ADDR;
         addr_d   = addr_sel & 8'h7f;
         wdata_d  = (idx_d == 3'd0) ? CTRL1_VAL : CTRL4_VAL;
      end else if (state_d == RD_ISSUE) begin
         en_d     = 1'b1;
         read_d   = 1'b1;
         addr_sel = OUT_BASE + {5'd0, idx_d};
         addr_d   = addr_sel & 8'h7f;
         wdata_d  = 8'h00;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= 3'd0;
         shadow_q <= 48'd0;
         gap_q    <= 16'd0;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
         read_q   <= 1'b0;
         en_q     <= 1'b0;
         ax_q     <= 16'd0;
         ay_q     <= 16'd0;
         az_q     <= 16'd0;
         sv_q     <= 1'b0;
         init_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         gap_q    <= gap_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         read_q   <= read_d;
         en_q     <= en_d;
         ax_q     <= ax_d;
         ay_q     <= ay_d;
         az_q     <= az_d;
         sv_q     <= sv_d;
         init_q   <= init_d;
         busy_q   <= busy_d;
      end
   end

   assign spi_addr     = addr_q;
   assign spi_wdata    = wdata_q;
   assign spi_read     = read_q;
   assign spi_enable   = en_q;
   assign accel_x      = ax_q;
   assign accel_y      = ay_q;
   assign accel_z      = az_q;
   assign sample_valid = sv_q;
   assign init_done    = init_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_accel_poll_seq.sv
// Bench for accel_poll_seq: SPI responder model, transaction and sample
// scoreboards, directed init / burst / run-drop / reset scenarios.
module tb_accel_poll_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        spi_done = 1'b0;
   logic [7:0]  spi_rdata = 8'h00;
   logic [7:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic        spi_read;
   logic        spi_enable;
   logic [15:0] accel_x;
   logic [15:0] accel_y;
   logic [15:0] accel_z;
   logic        sample_valid;
   logic        init_done;
   logic        busy;

   accel_poll_seq #(.GAP_CYCLES(16'd10)) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .spi_done(spi_done),
      .spi_rdata(spi_rdata),
      .spi_addr(spi_addr),
      .spi_wdata(spi_wdata),
      .spi_read(spi_read),
      .spi_enable(spi_enable),
      .accel_x(accel_x),
      .accel_y(accel_y),
      .accel_z(accel_z),
      .sample_valid(sample_valid),
      .init_done(init_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
   endtask

   // Read data per burst, bytes for addr 0x28..0x2D.
   logic [7:0] vec [4][6] = '{
      '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80},
      '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'hFF, 8'hFF},
      '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44},
      '{8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE}
   };
   // Hand-computed samples, packed {z, y, x}.
   logic [47:0] exps [4] = '{
      {16'h8001, 16'hABCD, 16'h1234},
      {16'hFFFF, 16'h8000, 16'h7FFF},
      {16'h4433, 16'h2211, 16'h0000},
      {16'hDEF0, 16'h9ABC, 16'h5678}
   };

   logic [16:0] txq [$];
   logic [47:0] smq [$];

   // SPI responder: done 33 cycles after the enable cycle.
   int         pend = 0;
   int         burst = 0;
   logic [7:0] paddr = 8'h00;
   logic       pread = 1'b0;
   initial forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (!reset) begin
         pend = 0;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            spi_done = 1'b1;
            if (pread && paddr >= 8'h28 && paddr <= 8'h2D) begin
               spi_rdata = vec[burst % 4][paddr - 8'h28];
               if (paddr == 8'h2D) burst++;
            end else begin
               spi_rdata = 8'h00;
            end
         end
      end
      if (reset && spi_enable) begin
         pend  = 33;
         paddr = spi_addr;
         pread = spi_read;
      end
   end

   // Monitor: transaction scoreboard, sample scoreboard, timestamps.
   int   n_en = 0;
   int   samples = 0;
   int   t_first_en = -1;
   int   t_init = -1;
   int   rd_start [$];
   logic prev_en = 1'b0;
   logic prev_init = 1'b0;
   logic [47:0] e;
   initial forever begin
      @(negedge clk);
      if (spi_enable) begin
         n_en++;
         check("en_not_back_to_back", {63'd0, prev_en}, 64'd0);
         check("addr_bit7", {63'd0, spi_addr[7]}, 64'd0);
         if (t_first_en < 0) t_first_en = cyc;
         if (spi_read && spi_addr == 8'h28) rd_start.push_back(cyc);
         if (txq.size() == 0) begin
            n_checks++;
            $display("FAIL txn_unexpected: got addr %0h wdata %0h read %0b",
                     spi_addr, spi_wdata, spi_read);
         end else begin
            check("txn", {47'd0, spi_addr, spi_wdata, spi_read},
                  {47'd0, txq.pop_front()});
         end
      end
      prev_en = spi_enable;
      if (init_done && !prev_init) t_init = cyc;
      prev_init = init_done;
      if (sample_valid) begin
         samples++;
         if (smq.size() == 0) begin
            n_checks++;
            $display("FAIL sample_unexpected: got x %0h y %0h z %0h",
                     accel_x, accel_y, accel_z);
         end else begin
            e = smq.pop_front();
            check("accel_x", {48'd0, accel_x}, {48'd0, e[15:0]});
            check("accel_y", {48'd0, accel_y}, {48'd0, e[31:16]});
            check("accel_z", {48'd0, accel_z}, {48'd0, e[47:32]});
         end
      end
   end

   task automatic wait_samples(input int n, input int budget);
      for (int i = 0; i < budget && samples < n; i++) @(negedge clk);
      check("wait_samples", {63'd0, samples >= n}, 64'd1);
   endtask

   task automatic wait_en(input logic [7:0] a, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (spi_enable && spi_addr == a) hit = 1'b1;
      end
      check("wait_en", {63'd0, hit}, 64'd1);
   endtask

   task automatic push_cfg();
      txq.push_back({8'h20, 8'h57, 1'b0});
      txq.push_back({8'h23, 8'h08, 1'b0});
   endtask

   task automatic push_burst(input int k);
      for (int i = 0; i < 6; i++) txq.push_back({8'h28 + 8'(i), 8'h00, 1'b1});
      smq.push_back(exps[k]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_spi"}, {46'd0, spi_addr, spi_wdata, spi_read, spi_enable},
            64'd0);
      check({tag, "_status"}, {61'd0, sample_valid, init_done, busy}, 64'd0);
      check({tag, "_accel"}, {16'd0, accel_z, accel_y, accel_x}, 64'd0);
   endtask

   initial begin
      reset = 1'b0;
      run   = 1'b0;
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (50) @(negedge clk);
      check_all_zero("idle");
      check("idle_no_enable", 64'(n_en), 64'd0);

      push_cfg();
      push_burst(0);
      push_burst(1);
      push_burst(2);
      run = 1'b1;
      wait_samples(1, 600);
      check("init_latency", 64'(t_init - t_first_en), 64'd68);
      check("init_done_high", {63'd0, init_done}, 64'd1);
      wait_samples(2, 400);
      wait_en(8'h2A, 400);
      repeat (5) @(negedge clk);
      run = 1'b0;
      wait_samples(3, 400);
      repeat (30) @(negedge clk);
      check("run_drop_busy", {63'd0, busy}, 64'd0);
      check("burst_count", 64'(rd_start.size()), 64'd3);
      if (rd_start.size() == 3) begin
         check("burst_period_1", 64'(rd_start[1] - rd_start[0]), 64'd216);
         check("burst_period_2", 64'(rd_start[2] - rd_start[1]), 64'd216);
      end
      check("accel_held", {16'd0, accel_z, accel_y, accel_x},
            {16'd0, exps[2]});
      check("enable_total", 64'(n_en), 64'd20);
      check("txq_drained", 64'(txq.size()), 64'd0);
      check("smq_drained", 64'(smq.size()), 64'd0);

      txq.push_back({8'h28, 8'h00, 1'b1});
      txq.push_back({8'h29, 8'h00, 1'b1});
      run = 1'b1;
      wait_en(8'h29, 100);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      push_cfg();
      push_burst(3);
      reset = 1'b1;
      wait_samples(4, 600);
      run = 1'b0;
      repeat (30) @(negedge clk);
      check("final_busy", {63'd0, busy}, 64'd0);
      check("final_init_done", {63'd0, init_done}, 64'd1);
      check("final_accel", {16'd0, accel_z, accel_y, accel_x},
            {16'd0, exps[3]});
      check("final_txq", 64'(txq.size()), 64'd0);
      check("final_smq", 64'(smq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: run did not finish");
      $fatal(1);
   end

endmodule
